nasti_rd_order_ctrl: RTL and testbench
======================================

Name: nasti_rd_order_ctrl

Overview:
- Read-ordering controller placed between an upstream NASTI master's AR/R channels and the address-decoding demux.
- The demux routes reads by address and merges R beats with a round-robin arbiter, so same-ID reads sent to different ports could return out of order.
- This block tracks outstanding reads per ID and the target port of each ID.
- It stalls any AR that would send an ID to a different port while that ID still has reads in flight.

Parameters:
- ID_WIDTH, 1, width of ar_id/r_id; table depth = 2**ID_WIDTH.
- MAX_OUTSTANDING, 4, maximum in-flight reads per ID (>=1).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), per-ID counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ar_valid  in  1  upstream AR valid.
- ar_id  in  ID_WIDTH  upstream AR id.
- ar_port  in  3  target port index, decoded from ar_addr by the same base/mask match as the demux.
- ar_ready  out  1  to upstream.
- ar_valid_dn  out  1  to demux master-side AR valid.
- ar_ready_dn  in  1  from demux AR ready.
- r_valid  in  1  R beat valid, monitored on the demux master side.
- r_ready  in  1  R ready, monitored.
- r_last  in  1  R last, monitored.
- r_id  in  ID_WIDTH  R id, monitored.
- busy  out  1  any ID has a nonzero count.
- stall_cnt  out  16  saturating count of cycles with ar_valid=1 and the issue gate closed.
- err  out  1  sticky: R last received for an ID whose count is 0.

Behaviour:
- State per ID i:
  - cnt[i] (CNT_WIDTH bits).
  - port[i] (3 bits).
  - Reset: cnt=0, port=0.
- Issue gate, combinational:
  - allow = (cnt[ar_id]==0) || (port[ar_id]==ar_port && cnt[ar_id]<MAX_OUTSTANDING).
  - ar_valid_dn = ar_valid && allow.
  - ar_ready = ar_ready_dn && allow.
  - Zero added latency. ar_valid_dn never depends on ar_ready_dn.
- AR accept = ar_valid && ar_ready (equivalently ar_valid_dn && ar_ready_dn).
  - On accept: cnt[ar_id]++ and port[ar_id] <= ar_port.
- R retire = r_valid && r_ready && r_last.
  - On retire with cnt[r_id]!=0: cnt[r_id]--.
  - On retire with cnt[r_id]==0: count is unchanged and err <= 1.
- Same cycle, same ID for accept and retire: cnt unchanged; port still written with ar_port.
  - Legal because the gate guarantees a matching port or a count of 0→1.
  - Case cnt==0 with both events: the retire counts as the error case, err <= 1, and cnt becomes 1.
- Same cycle, different IDs: both updates apply independently.
- Non-last R beats never change state.
- Counter never exceeds MAX_OUTSTANDING; the gate enforces this.
- stall_cnt increments when ar_valid && !allow and saturates at 16'hFFFF. It is cleared only by rst.
- busy is registered: busy <= (OR of all next-state cnt != 0). Reset value 0.
- err reset value 0; cleared only by rst.
- Reset mid-operation clears all tracking.
  - R beats arriving afterwards for pre-reset reads set err.
  - The environment must reset the demux and slaves together.
- Outputs at reset: ar_ready=0 and ar_valid_dn=0 unless inputs request (combinational), busy=0, stall_cnt=0, err=0.

Decomposition:
- Shared package nasti_pkg holds:
  - the 3-bit port index type nasti_port_t;
  - NASTI_MAX_PORTS=8;
  - the port_match base/mask function, so the controller and demux decode identically. An integrator instantiates the decoder feeding ar_port.
- One natural sub-module: nasti_id_tracker.
  - A single-ID counter-plus-port register with inc/dec/port_wr inputs and cnt/port outputs.
  - Generated 2**ID_WIDTH times.
  - Issue gate, stall counter and err stay in the top.

Test Plan:
- Same-ID same-port pipelining (MAX_OUTSTANDING=4): issue 4 ARs id=0 port=2 back-to-back with ar_ready_dn=1 → all accepted in 4 cycles; the 5th stalls; stall_cnt increments each stalled cycle; busy=1.
- Port conflict: AR id=1 port=3 accepted, then AR id=1 port=5 → ar_valid_dn=0 and ar_ready=0 until R last id=1 retires. The AR is accepted the cycle after the retire, at the earliest in the same cycle cnt reaches 0 as seen by the gate.
- Different IDs, different ports: AR id=0 port=1 outstanding; AR id=1 port=4 → accepted immediately; no stalls.
- Simultaneous accept and retire on id=0 with cnt=2, same port → cnt stays 2; busy stays 1.
- Spurious R last id=1 with cnt[1]=0 → err=1 and remains set; counts unchanged; rst clears err, busy and stall_cnt to 0.
- Non-last R beats: 3-beat burst on id=0 → cnt decrements only on the beat with r_last=1; stall_cnt saturates at 16'hFFFF under a forced 70000-cycle stall.

Source files
------------

// File: rtl/nasti_pkg.sv
// Shared NASTI definitions: port index type and the address decode used by
// both the read-ordering controller's decoder and the demux, so the two
// always agree on which port an address maps to.
package nasti_pkg;

   localparam int NASTI_MAX_PORTS = 8;
   localparam int NASTI_ADDR_W    = 32;

   typedef logic [$clog2(NASTI_MAX_PORTS)-1:0] nasti_port_t;
   typedef logic [NASTI_ADDR_W-1:0]            nasti_addr_t;

   // An address belongs to a port when every bit selected by mask equals base.
   function automatic logic port_match(input nasti_addr_t addr,
                                       input nasti_addr_t base,
                                       input nasti_addr_t mask);
      return ((addr ^ base) & mask) == '0;
   endfunction

   // Full decode: lowest-numbered matching port wins, port 0 when none match.
   function automatic nasti_port_t port_decode(
         input nasti_addr_t                                    addr,
         input logic [NASTI_MAX_PORTS-1:0][NASTI_ADDR_W-1:0]   bases,
         input logic [NASTI_MAX_PORTS-1:0][NASTI_ADDR_W-1:0]   masks);
      nasti_port_t p;
      p = '0;
      for (int i = NASTI_MAX_PORTS - 1; i >= 0; i--) begin
         if (port_match(addr, bases[i], masks[i])) begin
            p = nasti_port_t'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/nasti_rd_order_ctrl_if.sv
// AR handshake (upstream and demux side) plus the monitored R channel of the
// read-ordering controller. The slave modport is the controller's view.
interface nasti_rd_order_ctrl_if
   import nasti_pkg::*;
#(
   parameter int ID_WIDTH = 1
);
   logic                ar_valid;
   logic [ID_WIDTH-1:0] ar_id;
   nasti_port_t         ar_port;
   logic                ar_ready;
   logic                ar_valid_dn;
   logic                ar_ready_dn;
   logic                r_valid;
   logic                r_ready;
   logic                r_last;
   logic [ID_WIDTH-1:0] r_id;

   modport master (
      output ar_valid, ar_id, ar_port, ar_ready_dn,
      output r_valid, r_ready, r_last, r_id,
      input  ar_ready, ar_valid_dn
   );

   modport slave (
      input  ar_valid, ar_id, ar_port, ar_ready_dn,
      input  r_valid, r_ready, r_last, r_id,
      output ar_ready, ar_valid_dn
   );
endinterface

// File: rtl/nasti_id_tracker.sv
// Outstanding-read counter and last-used target port for a single AXI ID.
module nasti_id_tracker
   import nasti_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 dec,
   input  logic                 port_wr,
   input  nasti_port_t          port_in,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic [CNT_WIDTH-1:0] cnt_nxt,
   output nasti_port_t          port
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

   // Next count: inc and dec together cancel; the ceiling hold is a backstop
   // behind the issue gate, which already refuses a full ID.
   always_comb begin
      cnt_nxt = cnt;
      unique case ({inc, dec})
         2'b10:   cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
         2'b01:   cnt_nxt = cnt - CNT_WIDTH'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   // Count and port registers; port follows every accepted AR for this ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         port <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (port_wr) begin
            port <= port_in;
         end
      end
   end

endmodule

// File: rtl/nasti_rd_order_ctrl.sv
// Read-ordering controller: holds back any AR that would send an ID to a
// different demux port while earlier reads of that ID are still in flight,
// so R beats of one ID can never be reordered by the demux arbiter.
module nasti_rd_order_ctrl
   import nasti_pkg::*;
#(
   parameter int ID_WIDTH        = 1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   nasti_rd_order_ctrl_if.slave  bus,
   output logic                  busy,
   output logic [15:0]           stall_cnt,
   output logic                  err
);

   localparam int                   DEPTH   = 2 ** ID_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

   logic [DEPTH-1:0][CNT_WIDTH-1:0] cnt;
   logic [DEPTH-1:0][CNT_WIDTH-1:0] cnt_nxt;
   nasti_port_t [DEPTH-1:0]         port;
   logic [DEPTH-1:0]                inc_vec;
   logic [DEPTH-1:0]                dec_vec;
   logic [DEPTH-1:0]                spur_vec;
   logic [DEPTH-1:0]                busy_vec;

   logic [CNT_WIDTH-1:0] sel_cnt;
   nasti_port_t          sel_port;
   logic                 allow;
   logic                 accept;
   logic                 retire;

   // Issue gate: an idle ID may go anywhere, a busy ID only to its current
   // port and only while it has headroom. Purely combinational, no latency.
   always_comb begin
      sel_cnt  = cnt[bus.ar_id];
      sel_port = port[bus.ar_id];
      allow    = (sel_cnt == '0) ||
                 ((sel_port == bus.ar_port) && (sel_cnt < CNT_MAX));
   end

   assign bus.ar_valid_dn = bus.ar_valid & allow;
   assign bus.ar_ready    = bus.ar_ready_dn & allow;

   assign accept = bus.ar_valid & bus.ar_ready_dn & allow;
   assign retire = bus.r_valid & bus.r_ready & bus.r_last;

   for (genvar i = 0; i < DEPTH; i++) begin : g_id
      logic ret_hit;

      assign inc_vec[i]  = accept && (bus.ar_id == ID_WIDTH'(i));
      assign ret_hit     = retire && (bus.r_id == ID_WIDTH'(i));
      assign dec_vec[i]  = ret_hit && (cnt[i] != '0);
      assign spur_vec[i] = ret_hit && (cnt[i] == '0);
      assign busy_vec[i] = (cnt_nxt[i] != '0);

      nasti_id_tracker #(
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .CNT_WIDTH       (CNT_WIDTH)
      ) u_trk (
         .clk     (clk),
         .rst     (rst),
         .inc     (inc_vec[i]),
         .dec     (dec_vec[i]),
         .port_wr (inc_vec[i]),
         .port_in (bus.ar_port),
         .cnt     (cnt[i]),
         .cnt_nxt (cnt_nxt[i]),
         .port    (port[i])
      );
   end

   // busy reflects the counts as they will be after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
      end else begin
         busy <= |busy_vec;
      end
   end

   // Saturating count of cycles where a request sits behind a closed gate.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (bus.ar_valid && !allow && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Sticky flag for an R last arriving on an ID with nothing outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (|spur_vec) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nasti_rd_order_ctrl.sv
// Bench for nasti_rd_order_ctrl: directed vector table, a few hand-written
// corner sequences, randomized traffic against a count/port reference model,
// and a long forced stall for stall_cnt saturation.
module tb_nasti_rd_order_ctrl;
   import nasti_pkg::*;

   localparam int ID_WIDTH = 1;
   localparam int MAXO     = 4;
   localparam int NID      = 2 ** ID_WIDTH;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] stall_cnt;
   logic        err;

   always #5 clk = ~clk;

   nasti_rd_order_ctrl_if #(.ID_WIDTH(ID_WIDTH)) bus ();

   nasti_rd_order_ctrl #(
      .ID_WIDTH        (ID_WIDTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .stall_cnt (stall_cnt),
      .err       (err)
   );

   typedef struct {
      logic r;
      logic av;
      int   id;
      int   port;
      logic rdn;
      logic rv;
      logic rr;
      logic rl;
      int   rid;
      logic e_vdn;
      logic e_rdy;
      logic e_busy;
      logic e_err;
      int   e_stall;
   } vec_t;

   vec_t tbl [26];

   int   m_cnt  [NID];
   int   m_port [NID];
   int   m_err;
   int   m_stall;
   int   m_busy;
   logic act_vdn;
   logic act_rdy;
   int   n_chk;
   int   n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NID; i++) begin
         m_cnt[i]  = 0;
         m_port[i] = 0;
      end
      m_err   = 0;
      m_stall = 0;
      m_busy  = 0;
   endtask

   // One clock: drive, check gate outputs mid-cycle, advance the model at the
   // edge, then check the registered outputs just after it.
   task automatic cycle(input logic r, input logic av, input int id, input int port,
                        input logic rdn, input logic rv, input logic rr, input logic rl,
                        input int rid);
      int  nc [NID];
      bit  allow;
      bit  acc;
      bit  ret;
      rst             = r;
      bus.ar_valid    = av;
      bus.ar_id       = ID_WIDTH'(id);
      bus.ar_port     = nasti_port_t'(port);
      bus.ar_ready_dn = rdn;
      bus.r_valid     = rv;
      bus.r_ready     = rr;
      bus.r_last      = rl;
      bus.r_id        = ID_WIDTH'(rid);
      @(negedge clk);
      allow   = (m_cnt[id] == 0) || (m_port[id] == port && m_cnt[id] < MAXO);
      act_vdn = bus.ar_valid_dn;
      act_rdy = bus.ar_ready;
      chk("mdl_ar_valid_dn", act_vdn, av && allow);
      chk("mdl_ar_ready", act_rdy, rdn && allow);
      acc = av && rdn && allow;
      ret = rv && rr && rl;
      for (int i = 0; i < NID; i++) nc[i] = m_cnt[i];
      if (acc) nc[id] = nc[id] + 1;
      if (ret) begin
         if (m_cnt[rid] == 0) m_err = 1;
         else nc[rid] = nc[rid] - 1;
      end
      if (acc) m_port[id] = port;
      if (av && !allow && m_stall < 65535) m_stall++;
      for (int i = 0; i < NID; i++) m_cnt[i] = nc[i];
      m_busy = 0;
      for (int i = 0; i < NID; i++) if (m_cnt[i] != 0) m_busy = 1;
      if (r) model_reset();
      @(posedge clk);
      #1;
      chk("mdl_busy", busy, m_busy);
      chk("mdl_err", err, m_err);
      chk("mdl_stall_cnt", stall_cnt, m_stall);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_port = '0; bus.ar_ready_dn = 1'b0;
      bus.r_valid = 1'b0; bus.r_ready = 1'b0; bus.r_last = 1'b0; bus.r_id = '0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      chk("reset_busy", busy, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_stall_cnt", stall_cnt, 16'h0);
      chk("reset_ar_valid_dn", bus.ar_valid_dn, 1'b0);
      chk("reset_ar_ready", bus.ar_ready, 1'b0);

      // r av id port rdn rv rr rl rid | vdn rdy busy err stall (after edge)
      tbl[0]  = '{0,1,0,2,1,0,0,0,0, 1,1,1,0,0};
      tbl[1]  = '{0,1,0,2,1,0,0,0,0, 1,1,1,0,0};
      tbl[2]  = '{0,1,0,2,1,0,0,0,0, 1,1,1,0,0};
      tbl[3]  = '{0,1,0,2,1,0,0,0,0, 1,1,1,0,0};
      tbl[4]  = '{0,1,0,2,1,0,0,0,0, 0,0,1,0,1};
      tbl[5]  = '{0,1,0,2,1,0,0,0,0, 0,0,1,0,2};
      tbl[6]  = '{0,0,0,0,0,1,1,1,0, 0,0,1,0,2};
      tbl[7]  = '{0,0,0,0,0,1,1,1,0, 0,0,1,0,2};
      tbl[8]  = '{0,1,0,2,1,1,1,1,0, 1,1,1,0,2};
      tbl[9]  = '{0,0,0,0,0,1,1,0,0, 0,0,1,0,2};
      tbl[10] = '{0,0,0,0,0,1,1,0,0, 0,0,1,0,2};
      tbl[11] = '{0,0,0,0,0,1,1,1,0, 0,0,1,0,2};
      tbl[12] = '{0,0,0,0,0,1,1,1,0, 0,0,0,0,2};
      tbl[13] = '{0,1,1,3,1,0,0,0,0, 1,1,1,0,2};
      tbl[14] = '{0,1,1,5,1,0,0,0,0, 0,0,1,0,3};
      tbl[15] = '{0,1,1,5,1,1,1,1,1, 0,0,0,0,4};
      tbl[16] = '{0,1,1,5,1,0,0,0,0, 1,1,1,0,4};
      tbl[17] = '{0,1,0,1,1,1,1,1,1, 1,1,1,0,4};
      tbl[18] = '{0,1,1,4,1,0,0,0,0, 1,1,1,0,4};
      tbl[19] = '{0,1,0,1,0,0,0,0,0, 1,0,1,0,4};
      tbl[20] = '{0,0,0,0,0,1,1,1,0, 0,0,1,0,4};
      tbl[21] = '{0,0,0,0,0,1,1,1,1, 0,0,0,0,4};
      tbl[22] = '{0,0,0,0,0,1,1,1,1, 0,0,0,1,4};
      tbl[23] = '{0,0,0,0,0,0,0,0,0, 0,0,0,1,4};
      tbl[24] = '{0,1,0,6,1,1,1,1,0, 1,1,1,1,4};
      tbl[25] = '{1,0,0,0,0,0,0,0,0, 0,0,0,0,0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 26; i++) begin
         cycle(tbl[i].r, tbl[i].av, tbl[i].id, tbl[i].port, tbl[i].rdn,
               tbl[i].rv, tbl[i].rr, tbl[i].rl, tbl[i].rid);
         chk($sformatf("tbl%0d_ar_valid_dn", i), act_vdn, tbl[i].e_vdn);
         chk($sformatf("tbl%0d_ar_ready", i), act_rdy, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
         chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, tbl[i].e_stall);
      end

      // Accept and spurious retire on an idle ID in the same cycle.
      cycle(0, 1, 0, 3, 1, 1, 1, 1, 0);
      chk("zero_both_err", err, 1'b1);
      chk("zero_both_busy", busy, 1'b1);
      cycle(0, 1, 0, 3, 1, 0, 0, 0, 0);
      chk("zero_both_follow_accept", act_rdy, 1'b1);
      // Reset mid-operation, then a late R last from before the reset.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_err", err, 1'b0);
      cycle(0, 0, 0, 0, 0, 1, 1, 1, 0);
      chk("late_r_err", err, 1'b1);
      chk("late_r_busy", busy, 1'b0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 2000; k++) begin
         cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, NID - 1)),
               int'($urandom_range(0, 2)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 4),
               int'($urandom_range(0, NID - 1)));
      end

      // Forced long stall: fill id 0, then hold a request against it.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < MAXO; k++) cycle(0, 1, 0, 2, 1, 0, 0, 0, 0);
      bus.ar_valid = 1'b1; bus.ar_id = '0; bus.ar_port = 3'd2; bus.ar_ready_dn = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_before", stall_cnt, 16'hFFFE);
      chk("sat_gate_closed", bus.ar_valid_dn, 1'b0);
      repeat (70000 - 65534) @(posedge clk);
      #1;
      chk("sat_hold", stall_cnt, 16'hFFFF);
      chk("sat_busy", busy, 1'b1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("final_reset_stall_cnt", stall_cnt, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
